alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request port and a valid/ready
// result port. Logic, shift, compare, add and sub finish in one cycle.
// mul/mulhu use a shift-add multiplier that takes WIDTH cycles.
// divu/remu use a restoring divider that also takes WIDTH cycles.
//
// Ports:
//   clk, reset           clock and asynchronous active-high reset
//   in_valid/in_ready    request handshake; in_ready is high only when idle
//   op, srca, srcb       operation code and operands, captured on acceptance
//   out_valid/out_ready  result handshake; the result is held until taken
//   result, zero         registered result and its zero flag
//
// Configuration macro ALU_SEQ_DIV_EN:
//   defined   -> divider built; divu/remu are iterative ops.
//   undefined -> no divider; divu/remu act as unknown codes and return zero
//                in one cycle.

module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b01000;
    localparam logic [4:0] OP_SLL   = 5'b00001;
    localparam logic [4:0] OP_SLT   = 5'b00010;
    localparam logic [4:0] OP_SLTU  = 5'b00011;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_SRL   = 5'b00101;
    localparam logic [4:0] OP_SRA   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b00110;
    localparam logic [4:0] OP_AND   = 5'b00111;
    localparam logic [4:0] OP_MUL   = 5'b10000;
    localparam logic [4:0] OP_MULHU = 5'b10001;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [4:0] OP_DIVU  = 5'b10100;
    localparam logic [4:0] OP_REMU  = 5'b10110;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic               hi_q, hi_d;

    logic [SW-1:0]      shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               is_iter;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] step_next;

`ifdef ALU_SEQ_DIV_EN
    logic               div_q, div_d;
    logic               is_div_op;
    logic [WIDTH:0]     div_tmp;
    logic [WIDTH-1:0]   div_rem;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
`endif

    // Single-cycle results straight from the input buses; stored on acceptance.
    always_comb begin
        shamt   = srcb[SW-1:0];
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = srca + srcb;
            OP_SUB:  alu_res = srca - srcb;
            OP_SLL:  alu_res = srca << shamt;
            OP_SLT:  alu_res[0] = $signed(srca) < $signed(srcb);
            OP_SLTU: alu_res[0] = srca < srcb;
            OP_XOR:  alu_res = srca ^ srcb;
            OP_SRL:  alu_res = srca >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(srca) >>> shamt);
            OP_OR:   alu_res = srca | srcb;
            OP_AND:  alu_res = srca & srcb;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        is_iter = (op == OP_MUL) || (op == OP_MULHU);
`ifdef ALU_SEQ_DIV_EN
        is_div_op = (op == OP_DIVU) || (op == OP_REMU);
        is_iter   = is_iter || is_div_op;
`endif
    end

    // Shift-add multiply: acc holds {partial product, remaining multiplier}.
    // The carry out of the add becomes the top bit after the right shift.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    // Restoring divide: acc holds {remainder, dividend/quotient}. A zero
    // divisor always subtracts, which yields all-ones quotient and
    // remainder equal to the dividend with no special case.
    assign div_tmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge   = div_tmp >= {1'b0, opnd_q};
    assign div_rem  = div_tmp[WIDTH-1:0] - opnd_q;
    assign div_next = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
                             : {div_tmp[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    assign step_next = div_q ? div_next : mul_next;
`else
    assign step_next = mul_next;
`endif

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
`ifdef ALU_SEQ_DIV_EN
        div_d       = div_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    in_ready_d = 1'b0;
                    if (is_iter) begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        hi_d    = (op == OP_MULHU);
`ifdef ALU_SEQ_DIV_EN
                        hi_d    = hi_d || (op == OP_REMU);
                        div_d   = is_div_op;
                        opnd_d  = is_div_op ? srcb : srca;
                        acc_d   = {{WIDTH{1'b0}}, (is_div_op ? srca : srcb)};
`else
                        opnd_d  = srca;
                        acc_d   = {{WIDTH{1'b0}}, srcb};
`endif
                    end else begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                    end
                end
            end
            BUSY: begin
                acc_d = step_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SW'(WIDTH - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = hi_q ? step_next[2*WIDTH-1:WIDTH]
                                       : step_next[WIDTH-1:0];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            opnd_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            hi_q        <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
`ifdef ALU_SEQ_DIV_EN
            div_q       <= div_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq at WIDTH=32. Each vector
// carries a hand-computed result and latency. Also covers holding a result
// while new requests are offered, and a reset that aborts a multiply.
// Divider expectations follow the ALU_SEQ_DIV_EN macro.

module tb_alu_seq;
    localparam int WIDTH = 32;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b01000;
    localparam logic [4:0] OP_SLL   = 5'b00001;
    localparam logic [4:0] OP_SLT   = 5'b00010;
    localparam logic [4:0] OP_SLTU  = 5'b00011;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_SRL   = 5'b00101;
    localparam logic [4:0] OP_SRA   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b00110;
    localparam logic [4:0] OP_AND   = 5'b00111;
    localparam logic [4:0] OP_MUL   = 5'b10000;
    localparam logic [4:0] OP_MULHU = 5'b10001;
    localparam logic [4:0] OP_DIVU  = 5'b10100;
    localparam logic [4:0] OP_REMU  = 5'b10110;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    int assertCount = 0;
    int failCount   = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .srca      (srca),
        .srcb      (srcb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one request, scrambles the buses after acceptance, waits for the
    // result (bounded), checks it, then takes it and checks the return to idle.
    task automatic applyStimulus(input string tag, input logic [4:0] opc,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expRes, input int expLat);
        int lat;
        checkOutput({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        op       = opc;
        srca     = a;
        srcb     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 5'b11111;
        srca     = 32'hDEADBEEF;
        srcb     = 32'h12345678;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, expLat);
        checkOutput({tag, "_result"}, result, expRes);
        checkOutput({tag, "_zero"}, zero, (expRes == 32'h0));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, out_valid, 0);
        checkOutput({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        srca      = '0;
        srcb      = '0;
        #1;
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_zero", zero, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus("sub_eq",   OP_SUB,  32'd5, 32'd5, 32'h0, 1);
        applyStimulus("sub_wrap", OP_SUB,  32'd0, 32'd1, 32'hFFFFFFFF, 1);
        applyStimulus("add",      OP_ADD,  32'd3, 32'd4, 32'd7, 1);
        applyStimulus("add_wrap", OP_ADD,  32'hFFFFFFFF, 32'd1, 32'h0, 1);
        applyStimulus("sll_mask", OP_SLL,  32'd1, 32'h23, 32'h8, 1);
        applyStimulus("sll_31",   OP_SLL,  32'd1, 32'd31, 32'h80000000, 1);
        applyStimulus("sra",      OP_SRA,  32'h80000000, 32'd4, 32'hF8000000, 1);
        applyStimulus("srl",      OP_SRL,  32'h80000000, 32'd4, 32'h08000000, 1);
        applyStimulus("sltu",     OP_SLTU, 32'd1, 32'hFFFFFFFF, 32'd1, 1);
        applyStimulus("slt",      OP_SLT,  32'd1, 32'hFFFFFFFF, 32'd0, 1);
        applyStimulus("slt_neg",  OP_SLT,  32'hFFFFFFFF, 32'd1, 32'd1, 1);
        applyStimulus("xor",      OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
        applyStimulus("or",       OP_OR,   32'h0000000F, 32'h000000F0, 32'h000000FF, 1);
        applyStimulus("and",      OP_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1);
        applyStimulus("unk_lo",   5'b01001, 32'd9, 32'd9, 32'h0, 1);
        applyStimulus("unk_hi",   5'b10010, 32'd9, 32'd9, 32'h0, 1);
        applyStimulus("mulhu_max", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        applyStimulus("mul_max",   OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
        applyStimulus("mul_small", OP_MUL,   32'd7, 32'd6, 32'd42, 33);
        applyStimulus("mulhu_2_32", OP_MULHU, 32'h00010000, 32'h00010000, 32'h1, 33);
        applyStimulus("mul_2_32",   OP_MUL,   32'h00010000, 32'h00010000, 32'h0, 33);
`ifdef ALU_SEQ_DIV_EN
        applyStimulus("divu",     OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        applyStimulus("remu",     OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        applyStimulus("divu_by0", OP_DIVU, 32'd100, 32'd0, 32'hFFFFFFFF, 33);
        applyStimulus("remu_by0", OP_REMU, 32'd100, 32'd0, 32'd100, 33);
        applyStimulus("divu_lt",  OP_DIVU, 32'd7, 32'd100, 32'd0, 33);
`else
        applyStimulus("divu_off", OP_DIVU, 32'd100, 32'd7, 32'h0, 1);
        applyStimulus("remu_off", OP_REMU, 32'd100, 32'd7, 32'h0, 1);
`endif

        // Hold a result in DONE while new requests are offered.
        in_valid = 1'b1;
        op       = OP_ADD;
        srca     = 32'd3;
        srcb     = 32'd4;
        @(posedge clk);
        #1;
        op   = OP_SUB;
        srca = 32'd100;
        srcb = 32'd1;
        checkOutput("hold_first_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_result", result, 32'd7);
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("hold_release_valid", out_valid, 0);
        checkOutput("hold_release_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold_no_queue", out_valid, 0);

        // Abort a multiply with reset five cycles in.
        in_valid = 1'b1;
        op       = OP_MULHU;
        srca     = 32'hFFFFFFFF;
        srcb     = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_in_ready", in_ready, 1);
        checkOutput("abort_result", result, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen  = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checkOutput("abort_no_result", seen, 0);
        applyStimulus("after_abort_mul", OP_MUL, 32'd7, 32'd6, 32'd42, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
